ladybird_bus_arbiter: RTL and testbench

- Two-requester arbiter that shares one ladybird_bus secondary (e.g. ladybird_ram) between instruction fetch (port 0) and load/store (port 1).
- Round-robin grant; address, write data and strobes are muxed to the secondary.
- Read responses are steered back to the issuing requester using an in-order owner FIFO.
- Sits between the core's two bus primaries and the memory-side bus.

---
 rtl/ladybird_config.sv | 9 +
 rtl/ladybird_bus_arbiter_if.sv | 52 +++++
 rtl/ladybird_owner_fifo.sv | 65 ++++++
 rtl/ladybird_bus_arbiter.sv | 94 +++++++++
 tb/tb_ladybird_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ladybird_config.sv
// rtl/ladybird_config.sv - shared constants and types for the ladybird bus arbiter
package ladybird_config;

   localparam int NUM_REQ = 2;

   // Identifies which requester issued an outstanding read
   typedef logic owner_id_t;

endpackage

// File: rtl/ladybird_bus_arbiter_if.sv
// rtl/ladybird_bus_arbiter_if.sv - requester and secondary bus signals around the arbiter
interface ladybird_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  m0_req;
   logic [ADDR_W-1:0]     m0_addr;
   logic [DATA_W/8-1:0]   m0_wstrb;
   logic [DATA_W-1:0]     m0_wdata;
   logic                  m0_gnt;
   logic                  m0_data_gnt;

   logic                  m1_req;
   logic [ADDR_W-1:0]     m1_addr;
   logic [DATA_W/8-1:0]   m1_wstrb;
   logic [DATA_W-1:0]     m1_wdata;
   logic                  m1_gnt;
   logic                  m1_data_gnt;

   logic [DATA_W-1:0]     m_rdata;

   logic                  s_req;
   logic [ADDR_W-1:0]     s_addr;
   logic [DATA_W/8-1:0]   s_wstrb;
   logic [DATA_W-1:0]     s_wdata;
   logic                  s_gnt;
   logic [DATA_W-1:0]     s_rdata;
   logic                  s_data_gnt;

   // Arbiter view: serves both requesters and drives the secondary bus
   modport master (
      input  m0_req, m0_addr, m0_wstrb, m0_wdata,
      output m0_gnt, m0_data_gnt,
      input  m1_req, m1_addr, m1_wstrb, m1_wdata,
      output m1_gnt, m1_data_gnt,
      output m_rdata,
      output s_req, s_addr, s_wstrb, s_wdata,
      input  s_gnt, s_rdata, s_data_gnt
   );

   // Environment view: requesters and the secondary memory
   modport slave (
      output m0_req, m0_addr, m0_wstrb, m0_wdata,
      input  m0_gnt, m0_data_gnt,
      output m1_req, m1_addr, m1_wstrb, m1_wdata,
      input  m1_gnt, m1_data_gnt,
      input  m_rdata,
      input  s_req, s_addr, s_wstrb, s_wdata,
      output s_gnt, s_rdata, s_data_gnt
   );

endinterface

// File: rtl/ladybird_owner_fifo.sv
// rtl/ladybird_owner_fifo.sv - in-order FIFO recording which requester owns each outstanding read
module ladybird_owner_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1,
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop_eff;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
      return (p == IDX_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty_o = (count_q == '0);
   assign pop_eff = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Next pointers and occupancy; push and pop together leave the count unchanged
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i)  wr_ptr_d = next_idx(wr_ptr_q);
      if (pop_eff) rd_ptr_d = next_idx(rd_ptr_q);
      case ({push_i, pop_eff})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; reset empties the FIFO
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset; only entries below count are ever read
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/ladybird_bus_arbiter.sv
// rtl/ladybird_bus_arbiter.sv - round-robin arbiter sharing one ladybird secondary between fetch and load/store
module ladybird_bus_arbiter
   import ladybird_config::*;
#(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                   clk,
   input  logic                   arst,
   ladybird_bus_arbiter_if.master bus,
   output logic                   err
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] sel;
   logic               rd_room;
   logic               accept;
   logic               sel_is_read;
   logic               push;
   logic               pop;
   logic               stray;
   owner_id_t          head_id;
   logic [CNT_W-1:0]   count;
   logic               empty;

   // ptr_q = 0 favours m0, 1 favours m1
   logic               ptr_q, ptr_d;
   logic               err_q, err_d;

   // Reads are throttled by the registered count, so a same-cycle pop never frees a slot
   always_comb begin
      rd_room = (count < CNT_W'(MAX_OUTSTANDING));
      elig[0] = ~arst & bus.m0_req & ((|bus.m0_wstrb) | rd_room);
      elig[1] = ~arst & bus.m1_req & ((|bus.m1_wstrb) | rd_room);
      sel[0]  = elig[0] & (~elig[1] | ~ptr_q);
      sel[1]  = elig[1] & (~elig[0] |  ptr_q);
   end

   assign bus.s_req   = |sel;
   assign bus.s_addr  = sel[0] ? bus.m0_addr  : (sel[1] ? bus.m1_addr  : '0);
   assign bus.s_wstrb = sel[0] ? bus.m0_wstrb : (sel[1] ? bus.m1_wstrb : '0);
   assign bus.s_wdata = sel[0] ? bus.m0_wdata : (sel[1] ? bus.m1_wdata : '0);

   assign bus.m0_gnt  = sel[0] & bus.s_gnt;
   assign bus.m1_gnt  = sel[1] & bus.s_gnt;

   assign accept      = bus.s_req & bus.s_gnt;
   assign sel_is_read = ~(|bus.s_wstrb);
   assign push        = accept & sel_is_read;

   // Responses go to the oldest outstanding owner; a response with no owner is a protocol error
   assign pop             = ~arst & bus.s_data_gnt & ~empty;
   assign stray           = ~arst & bus.s_data_gnt &  empty;
   assign bus.m0_data_gnt = pop & (head_id == 1'b0);
   assign bus.m1_data_gnt = pop & (head_id == 1'b1);
   assign bus.m_rdata     = bus.s_rdata;
   assign err             = err_q;

   // After an accept, favour the port that was not just served
   always_comb begin
      ptr_d = ptr_q;
      err_d = err_q | stray;
      if (accept) ptr_d = sel[0];
   end

   // Priority pointer and sticky error flag
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         ptr_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         err_q <= err_d;
      end
   end

   ladybird_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (1)
   ) u_fifo (
      .clk     (clk),
      .arst    (arst),
      .push_i  (push),
      .din_i   (sel[1]),
      .pop_i   (pop),
      .head_o  (head_id),
      .count_o (count),
      .empty_o (empty)
   );

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// tb/tb_ladybird_bus_arbiter.sv - directed self-checking bench for ladybird_bus_arbiter
module tb_ladybird_bus_arbiter;

   logic clk;
   logic arst;
   logic err;

   int n_tests = 0;
   int n_fail  = 0;

   ladybird_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   ladybird_bus_arbiter #(
      .ADDR_W          (32),
      .DATA_W          (32),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus),
      .err  (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Small RAM model: always grants, returns read data one cycle after accept
   logic [31:0] mem [16];
   logic        rd_pend_q;
   logic [31:0] rd_data_q;
   logic        init_mem;
   logic        auto_mode;
   logic        dgnt_man;

   assign bus.s_gnt      = 1'b1;
   assign bus.s_rdata    = rd_data_q;
   assign bus.s_data_gnt = auto_mode ? rd_pend_q : dgnt_man;

   always @(posedge clk) begin
      rd_pend_q <= 1'b0;
      if (init_mem) begin
         for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
         mem[0] <= 32'hA0A0_0000;
         mem[1] <= 32'hDEAD_BEEF;
         mem[2] <= 32'hB0B0_0002;
         rd_data_q <= 32'h0;
      end else if (bus.s_req && bus.s_gnt) begin
         if (bus.s_wstrb == 4'b0000) begin
            rd_pend_q <= 1'b1;
            rd_data_q <= mem[bus.s_addr[5:2]];
         end else begin
            for (int b = 0; b < 4; b++)
               if (bus.s_wstrb[b]) mem[bus.s_addr[5:2]][8*b +: 8] <= bus.s_wdata[8*b +: 8];
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic set_m0(input logic req, input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
      bus.m0_req = req; bus.m0_addr = addr; bus.m0_wstrb = strb; bus.m0_wdata = data;
   endtask

   task automatic set_m1(input logic req, input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
      bus.m1_req = req; bus.m1_addr = addr; bus.m1_wstrb = strb; bus.m1_wdata = data;
   endtask

   initial begin
      arst = 1'b1; init_mem = 1'b1; auto_mode = 1'b1; dgnt_man = 1'b0;
      set_m0(1'b0, 32'h0, 4'h0, 32'h0);
      set_m1(1'b0, 32'h0, 4'h0, 32'h0);

      // Reset state: requests present but everything held low
      @(negedge clk);
      set_m0(1'b1, 32'h4, 4'h0, 32'h0);
      set_m1(1'b1, 32'h8, 4'h0, 32'h0);
      #1;
      check_eq("rst_m0_gnt", bus.m0_gnt, 0);
      check_eq("rst_m1_gnt", bus.m1_gnt, 0);
      check_eq("rst_s_req",  bus.s_req, 0);
      check_eq("rst_err",    err, 0);
      check_eq("rst_count",  dut.u_fifo.count_o, 0);

      // Single read from m0
      @(negedge clk);
      arst = 1'b0; init_mem = 1'b0;
      set_m1(1'b0, 32'h0, 4'h0, 32'h0);
      set_m0(1'b1, 32'h4, 4'h0, 32'h0);
      #1;
      check_eq("sr_m0_gnt",  bus.m0_gnt, 1);
      check_eq("sr_m1_gnt",  bus.m1_gnt, 0);
      check_eq("sr_s_addr",  bus.s_addr, 32'h4);
      @(negedge clk);
      set_m0(1'b0, 32'h0, 4'h0, 32'h0);
      #1;
      check_eq("sr_m0_dgnt", bus.m0_data_gnt, 1);
      check_eq("sr_m1_dgnt", bus.m1_data_gnt, 0);
      check_eq("sr_rdata",   bus.m_rdata, 32'hDEAD_BEEF);
      check_eq("sr_idle_addr", bus.s_addr, 0);

      // Contention from reset: grants alternate, data follows one cycle later
      @(negedge clk);
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
      set_m0(1'b1, 32'h0, 4'h0, 32'h0);
      set_m1(1'b1, 32'h8, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq($sformatf("ct%0d_m0_gnt", i), bus.m0_gnt, (i % 2 == 0) ? 1 : 0);
         check_eq($sformatf("ct%0d_m1_gnt", i), bus.m1_gnt, (i % 2 == 1) ? 1 : 0);
         check_eq($sformatf("ct%0d_m0_dgnt", i), bus.m0_data_gnt, (i % 2 == 1) ? 1 : 0);
         check_eq($sformatf("ct%0d_m1_dgnt", i), bus.m1_data_gnt, (i > 0 && i % 2 == 0) ? 1 : 0);
         if (i > 0)
            check_eq($sformatf("ct%0d_rdata", i), bus.m_rdata, (i % 2 == 1) ? 32'hA0A0_0000 : 32'hB0B0_0002);
         @(negedge clk);
      end
      set_m0(1'b0, 32'h0, 4'h0, 32'h0);
      set_m1(1'b0, 32'h0, 4'h0, 32'h0);
      #1;
      check_eq("ct_tail_m1_dgnt", bus.m1_data_gnt, 1);

      // FIFO full: responses withheld, only two reads accepted
      @(negedge clk);
      auto_mode = 1'b0; dgnt_man = 1'b0;
      set_m0(1'b1, 32'h0, 4'h0, 32'h0);
      set_m1(1'b1, 32'h8, 4'h0, 32'h0);
      #1;
      check_eq("ff_c0_m0_gnt", bus.m0_gnt, 1);
      @(negedge clk); #1;
      check_eq("ff_c1_m1_gnt", bus.m1_gnt, 1);
      @(negedge clk); #1;
      check_eq("ff_c2_m0_gnt", bus.m0_gnt, 0);
      check_eq("ff_c2_m1_gnt", bus.m1_gnt, 0);
      check_eq("ff_c2_count",  dut.u_fifo.count_o, 2);
      @(negedge clk);
      dgnt_man = 1'b1;
      #1;
      check_eq("ff_c3_m0_dgnt", bus.m0_data_gnt, 1);
      check_eq("ff_c3_m1_dgnt", bus.m1_data_gnt, 0);
      check_eq("ff_c3_m0_gnt",  bus.m0_gnt, 0);
      check_eq("ff_c3_m1_gnt",  bus.m1_gnt, 0);
      @(negedge clk);
      dgnt_man = 1'b0;
      #1;
      check_eq("ff_c4_m0_gnt", bus.m0_gnt, 1);
      check_eq("ff_c4_m1_gnt", bus.m1_gnt, 0);
      @(negedge clk);
      set_m0(1'b0, 32'h0, 4'h0, 32'h0);

      // Write bypasses the full FIFO
      set_m1(1'b1, 32'h8, 4'b0011, 32'h0000_1234);
      #1;
      check_eq("wb_m1_gnt",   bus.m1_gnt, 1);
      check_eq("wb_s_wstrb",  bus.s_wstrb, 4'b0011);
      check_eq("wb_s_wdata",  bus.s_wdata, 32'h0000_1234);
      @(negedge clk);
      set_m1(1'b0, 32'h0, 4'h0, 32'h0);
      #1;
      check_eq("wb_count", dut.u_fifo.count_o, 2);

      // Drain the two withheld reads in order: m1 then m0
      dgnt_man = 1'b1;
      #1;
      check_eq("dr_m1_dgnt", bus.m1_data_gnt, 1);
      @(negedge clk); #1;
      check_eq("dr_m0_dgnt", bus.m0_data_gnt, 1);
      @(negedge clk);
      dgnt_man = 1'b0; auto_mode = 1'b1;
      #1;
      check_eq("dr_count", dut.u_fifo.count_o, 0);
      set_m0(1'b1, 32'h8, 4'h0, 32'h0);
      #1;
      check_eq("rb_m0_gnt", bus.m0_gnt, 1);
      @(negedge clk);
      set_m0(1'b0, 32'h0, 4'h0, 32'h0);
      #1;
      check_eq("rb_m0_dgnt", bus.m0_data_gnt, 1);
      check_eq("rb_rdata",   bus.m_rdata, 32'hB0B0_1234);

      // Stray response with nothing outstanding
      @(negedge clk);
      auto_mode = 1'b0; dgnt_man = 1'b1;
      #1;
      check_eq("st_m0_dgnt", bus.m0_data_gnt, 0);
      check_eq("st_m1_dgnt", bus.m1_data_gnt, 0);
      @(negedge clk);
      dgnt_man = 1'b0;
      #1;
      check_eq("st_err", err, 1);
      repeat (3) @(negedge clk);
      #1;
      check_eq("st_err_held", err, 1);

      // Reset with two reads outstanding
      @(negedge clk);
      set_m0(1'b1, 32'h0, 4'h0, 32'h0);
      set_m1(1'b1, 32'h8, 4'h0, 32'h0);
      repeat (2) @(negedge clk);
      #1;
      check_eq("rm_count_pre", dut.u_fifo.count_o, 2);
      arst = 1'b1; dgnt_man = 1'b1;
      #1;
      check_eq("rm_m0_gnt",  bus.m0_gnt, 0);
      check_eq("rm_m1_gnt",  bus.m1_gnt, 0);
      check_eq("rm_s_req",   bus.s_req, 0);
      check_eq("rm_m0_dgnt", bus.m0_data_gnt, 0);
      check_eq("rm_m1_dgnt", bus.m1_data_gnt, 0);
      check_eq("rm_count",   dut.u_fifo.count_o, 0);
      check_eq("rm_err",     err, 0);
      @(negedge clk);
      arst = 1'b0; dgnt_man = 1'b0;
      set_m0(1'b0, 32'h0, 4'h0, 32'h0);
      #1;
      check_eq("rm_m1_alone_gnt", bus.m1_gnt, 1);
      @(negedge clk);
      arst = 1'b1;
      set_m1(1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      arst = 1'b0;
      set_m0(1'b1, 32'h0, 4'h0, 32'h0);
      set_m1(1'b1, 32'h8, 4'h0, 32'h0);
      #1;
      check_eq("rm_both_m0_gnt", bus.m0_gnt, 1);
      check_eq("rm_both_m1_gnt", bus.m1_gnt, 0);
      @(negedge clk);
      set_m0(1'b0, 32'h0, 4'h0, 32'h0);
      set_m1(1'b0, 32'h0, 4'h0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
